// File: rtl/pipelined_alu_pkg.sv
// Opcodes, flag bundle and the width-generic ALU function used by alu_core.
// Arithmetic is done at MAX_W bits and masked down to the caller's width.
package pipelined_alu_pkg;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_SLT = 3'd5;
  localparam logic [2:0] OP_SLL = 3'd6;
  localparam logic [2:0] OP_SRL = 3'd7;

  localparam int MAX_W = 64;

  typedef struct packed {
    logic zero;
    logic neg;
    logic carry;
    logic ovf;
  } flags_t;

  localparam flags_t FLAGS_RST = '{zero: 1'b1, neg: 1'b0, carry: 1'b0, ovf: 1'b0};

  typedef struct packed {
    logic [MAX_W-1:0] result;
    flags_t           flags;
  } alu_res_t;

  function automatic alu_res_t alu_compute(input logic [MAX_W-1:0] a,
                                           input logic [MAX_W-1:0] b,
                                           input logic [2:0]       op,
                                           input int               width);
    logic [MAX_W:0] mask;
    logic [MAX_W:0] sum;
    logic [MAX_W:0] diff;
    logic [MAX_W:0] res;
    logic [5:0]     sh;
    logic           a_s;
    logic           b_s;
    logic           r_s;
    alu_res_t       out;
    mask = {1'b0, {MAX_W{1'b1}}} >> (MAX_W - width);
    sum  = {1'b0, a} + {1'b0, b};
    diff = {1'b0, a} - {1'b0, b};
    sh   = b[5:0] & 6'(width - 1);
    a_s  = a[6'(width - 1)];
    b_s  = b[6'(width - 1)];
    out  = '0;
    case (op)
      OP_ADD: begin
        res = sum;
        out.flags.carry = sum[7'(width)];
      end
      OP_SUB: begin
        res = diff;
        out.flags.carry = diff[7'(width)];
      end
      OP_AND:  res = {1'b0, a & b};
      OP_OR:   res = {1'b0, a | b};
      OP_XOR:  res = {1'b0, a ^ b};
      // Same-sign operands compare correctly as unsigned values.
      OP_SLT:  res = (a_s != b_s) ? {{MAX_W{1'b0}}, a_s} : {{MAX_W{1'b0}}, (a < b)};
      OP_SLL:  res = {1'b0, a} << sh;
      OP_SRL:  res = {1'b0, a} >> sh;
      default: res = '0;
    endcase
    res = res & mask;
    r_s = res[7'(width - 1)];
    if (op == OP_ADD) begin
      out.flags.ovf = (a_s == b_s) && (r_s != a_s);
    end else if (op == OP_SUB) begin
      out.flags.ovf = (a_s != b_s) && (r_s != a_s);
    end else begin
      out.flags.ovf = 1'b0;
    end
    out.result     = res[MAX_W-1:0];
    out.flags.zero = (res == '0);
    out.flags.neg  = r_s;
    return out;
  endfunction

endpackage

// File: rtl/pipelined_alu_core.sv
// Combinational ALU: result and flags for one operand pair at WIDTH bits.
module alu_core
  import pipelined_alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [2:0]       op_i,
  output logic [WIDTH-1:0] result_o,
  output flags_t           flags_o
);

  logic [MAX_W-1:0] a_ext_s;
  logic [MAX_W-1:0] b_ext_s;
  alu_res_t         res_s;
  logic             unused_res_s;

  // Zero-extend operands and evaluate the shared ALU function.
  always_comb begin
    a_ext_s = '0;
    b_ext_s = '0;
    a_ext_s[WIDTH-1:0] = a_i;
    b_ext_s[WIDTH-1:0] = b_i;
    res_s = alu_compute(a_ext_s, b_ext_s, op_i, WIDTH);
  end

  assign result_o     = res_s.result[WIDTH-1:0];
  assign flags_o      = res_s.flags;
  assign unused_res_s = ^res_s.result;

endmodule

// File: rtl/pipelined_alu.sv
// Valid/ready ALU pipeline with accumulator feedback; STAGES=2 adds an
// operand register in front of the compute/output register.
module pipelined_alu
  import pipelined_alu_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter int               STAGES    = 1,
  parameter logic [WIDTH-1:0] ACC_RESET = '0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [2:0]       operation_i,
  input  logic             acc_i,
  input  logic             acc_clr_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] result_o,
  output logic             zero_o,
  output logic             neg_o,
  output logic             carry_o,
  output logic             ovf_o
);

  logic             out_ready_s;
  logic             core_valid_s;
  logic             core_load_s;
  logic             core_acc_s;
  logic [WIDTH-1:0] core_a_s;
  logic [WIDTH-1:0] core_b_s;
  logic [WIDTH-1:0] core_opa_s;
  logic [WIDTH-1:0] core_res_s;
  logic [2:0]       core_op_s;
  flags_t           core_flags_s;

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] result_q, result_d;
  flags_t           flags_q, flags_d;
  logic [WIDTH-1:0] acc_q, acc_d;

  assign out_ready_s = !out_valid_q || ready_i;
  assign core_load_s = core_valid_s && out_ready_s;
  // Accumulator is sampled as the transaction enters the output register.
  assign core_opa_s  = core_acc_s ? acc_q : core_a_s;

  generate
    if (STAGES == 2) begin : g_stage1
      logic             s1_valid_q, s1_valid_d;
      logic [WIDTH-1:0] s1_a_q, s1_a_d;
      logic [WIDTH-1:0] s1_b_q, s1_b_d;
      logic [2:0]       s1_op_q, s1_op_d;
      logic             s1_acc_q, s1_acc_d;

      assign ready_o      = !s1_valid_q || out_ready_s;
      assign core_valid_s = s1_valid_q;
      assign core_a_s     = s1_a_q;
      assign core_b_s     = s1_b_q;
      assign core_op_s    = s1_op_q;
      assign core_acc_s   = s1_acc_q;

      // Operand register next state: load on acceptance, empty on drain.
      always_comb begin
        s1_valid_d = s1_valid_q;
        s1_a_d     = s1_a_q;
        s1_b_d     = s1_b_q;
        s1_op_d    = s1_op_q;
        s1_acc_d   = s1_acc_q;
        if (ready_o) begin
          s1_valid_d = valid_i;
          if (valid_i) begin
            s1_a_d   = a_i;
            s1_b_d   = b_i;
            s1_op_d  = operation_i;
            s1_acc_d = acc_i;
          end else begin
            s1_a_d   = s1_a_q;
          end
        end else begin
          s1_valid_d = s1_valid_q;
        end
      end

      // Operand register state.
      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          s1_valid_q <= 1'b0;
          s1_a_q     <= '0;
          s1_b_q     <= '0;
          s1_op_q    <= OP_ADD;
          s1_acc_q   <= 1'b0;
        end else begin
          s1_valid_q <= s1_valid_d;
          s1_a_q     <= s1_a_d;
          s1_b_q     <= s1_b_d;
          s1_op_q    <= s1_op_d;
          s1_acc_q   <= s1_acc_d;
        end
      end
    end else begin : g_direct
      assign ready_o      = out_ready_s;
      assign core_valid_s = valid_i;
      assign core_a_s     = a_i;
      assign core_b_s     = b_i;
      assign core_op_s    = operation_i;
      assign core_acc_s   = acc_i;
    end
  endgenerate

  alu_core #(.WIDTH(WIDTH)) u_core (
    .a_i      (core_opa_s),
    .b_i      (core_b_s),
    .op_i     (core_op_s),
    .result_o (core_res_s),
    .flags_o  (core_flags_s)
  );

  // Output register and accumulator next state; a clear beats a result load.
  always_comb begin
    out_valid_d = out_valid_q;
    result_d    = result_q;
    flags_d     = flags_q;
    acc_d       = acc_q;
    if (core_load_s) begin
      out_valid_d = 1'b1;
      result_d    = core_res_s;
      flags_d     = core_flags_s;
    end else if (ready_i) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
    if (acc_clr_i) begin
      acc_d = ACC_RESET;
    end else if (core_load_s) begin
      acc_d = core_res_s;
    end else begin
      acc_d = acc_q;
    end
  end

  // Output register and accumulator state.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      out_valid_q <= 1'b0;
      result_q    <= '0;
      flags_q     <= FLAGS_RST;
      acc_q       <= ACC_RESET;
    end else begin
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      flags_q     <= flags_d;
      acc_q       <= acc_d;
    end
  end

  assign valid_o  = out_valid_q;
  assign result_o = result_q;
  assign zero_o   = flags_q.zero;
  assign neg_o    = flags_q.neg;
  assign carry_o  = flags_q.carry;
  assign ovf_o    = flags_q.ovf;

endmodule

// File: tb/tb_pipelined_alu.sv
// Bench for pipelined_alu: one STAGES=1 and one STAGES=2 instance, directed
// steps plus random streams checked against a sequential arithmetic model.
module tb_pipelined_alu;

  localparam logic [7:0] ACC_R0 = 8'h03;
  localparam logic [7:0] ACC_R1 = 8'h00;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       valid_i [2];
  logic       ready_o [2];
  logic [7:0] a_i [2];
  logic [7:0] b_i [2];
  logic [2:0] op_i [2];
  logic       acc_i [2];
  logic       acc_clr_i [2];
  logic       valid_o [2];
  logic       ready_i [2];
  logic [7:0] result_o [2];
  logic       zero_o [2];
  logic       neg_o [2];
  logic       carry_o [2];
  logic       ovf_o [2];

  int          checks = 0;
  int          errors = 0;
  logic [11:0] exp0 [$];
  logic [11:0] exp1 [$];
  logic [7:0]  macc [2];
  logic        hold_v [2];
  logic [11:0] hold_val [2];
  bit          rnd_stop;

  always #5 clk = ~clk;

  pipelined_alu #(.WIDTH(8), .STAGES(1), .ACC_RESET(ACC_R0)) u_dut0 (
    .clk_i(clk), .rst_i(rst), .valid_i(valid_i[0]), .ready_o(ready_o[0]),
    .a_i(a_i[0]), .b_i(b_i[0]), .operation_i(op_i[0]), .acc_i(acc_i[0]),
    .acc_clr_i(acc_clr_i[0]), .valid_o(valid_o[0]), .ready_i(ready_i[0]),
    .result_o(result_o[0]), .zero_o(zero_o[0]), .neg_o(neg_o[0]),
    .carry_o(carry_o[0]), .ovf_o(ovf_o[0]));

  pipelined_alu #(.WIDTH(8), .STAGES(2), .ACC_RESET(ACC_R1)) u_dut1 (
    .clk_i(clk), .rst_i(rst), .valid_i(valid_i[1]), .ready_o(ready_o[1]),
    .a_i(a_i[1]), .b_i(b_i[1]), .operation_i(op_i[1]), .acc_i(acc_i[1]),
    .acc_clr_i(acc_clr_i[1]), .valid_o(valid_o[1]), .ready_i(ready_i[1]),
    .result_o(result_o[1]), .zero_o(zero_o[1]), .neg_o(neg_o[1]),
    .carry_o(carry_o[1]), .ovf_o(ovf_o[1]));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: {zero, neg, carry, ovf, result} from plain integer arithmetic.
  function automatic logic [11:0] ref_alu(input logic [7:0] a, input logic [7:0] b,
                                          input logic [2:0] op);
    int ua, ub, sa, sb, r, sr;
    logic c, v;
    logic [7:0] res;
    ua = int'(a); ub = int'(b);
    sa = int'($signed(a)); sb = int'($signed(b));
    c = 1'b0; v = 1'b0; r = 0; sr = 0;
    case (op)
      3'd0: begin r = ua + ub; c = (r > 255); sr = sa + sb; v = (sr > 127) || (sr < -128); end
      3'd1: begin r = ua - ub; c = (ua < ub); sr = sa - sb; v = (sr > 127) || (sr < -128); end
      3'd2: r = ua & ub;
      3'd3: r = ua | ub;
      3'd4: r = ua ^ ub;
      3'd5: r = (sa < sb) ? 1 : 0;
      3'd6: r = ua << (ub % 8);
      3'd7: r = ua >> (ub % 8);
      default: r = 0;
    endcase
    res = 8'(r);
    return {res == 8'd0, res[7], c, v, res};
  endfunction

  // Monitor: scoreboard, hold-stability and model updates, sampled mid-cycle.
  always @(negedge clk) begin
    logic [11:0] got, e;
    if (rst) begin
      hold_v[0] = 1'b0;
      hold_v[1] = 1'b0;
    end else begin
      for (int d = 0; d < 2; d++) begin
        got = {zero_o[d], neg_o[d], carry_o[d], ovf_o[d], result_o[d]};
        if (hold_v[d] && valid_o[d]) check($sformatf("hold_stable%0d", d), 32'(got), 32'(hold_val[d]));
        if (valid_o[d] && !ready_i[d]) begin
          hold_v[d] = 1'b1;
          hold_val[d] = got;
        end else begin
          hold_v[d] = 1'b0;
        end
        if (valid_o[d] && ready_i[d]) begin
          if ((d == 0 && exp0.size() == 0) || (d == 1 && exp1.size() == 0)) begin
            checks++;
            errors++;
            $error("FAIL unexpected_output%0d observed=%0h expected=none", d, got);
          end else begin
            if (d == 0) e = exp0.pop_front();
            else        e = exp1.pop_front();
            check($sformatf("stream%0d", d), 32'(got), 32'(e));
          end
        end
        if (valid_i[d] && ready_o[d]) begin
          e = ref_alu(acc_i[d] ? macc[d] : a_i[d], b_i[d], op_i[d]);
          macc[d] = e[7:0];
          if (d == 0) exp0.push_back(e);
          else        exp1.push_back(e);
        end
        if (acc_clr_i[d]) macc[d] = (d == 0) ? ACC_R0 : ACC_R1;
      end
    end
  end

  task automatic send(input int d, input logic [7:0] a, input logic [7:0] b,
                      input logic [2:0] op, input logic acc);
    bit done;
    done = 1'b0;
    a_i[d] = a; b_i[d] = b; op_i[d] = op; acc_i[d] = acc; valid_i[d] = 1'b1;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      done = ready_o[d];
      @(posedge clk);
      #1;
    end
    if (!done) begin
      checks++;
      errors++;
      $error("FAIL send_timeout%0d observed=stalled expected=accepted", d);
    end
  endtask

  task automatic wait_drain(input int d);
    int n;
    n = (d == 0) ? exp0.size() : exp1.size();
    for (int i = 0; i < 200 && n != 0; i++) begin
      @(posedge clk);
      #1;
      n = (d == 0) ? exp0.size() : exp1.size();
    end
    check($sformatf("drain%0d", d), 32'(n), 32'd0);
  endtask

  task automatic random_phase(input int d);
    rnd_stop = 1'b0;
    fork
      begin
        for (int i = 0; i < 60; i++) begin
          send(d, 8'($urandom), 8'($urandom), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
          if ($urandom_range(0, 3) == 0) begin
            valid_i[d] = 1'b0;
            @(posedge clk);
            #1;
          end
        end
        valid_i[d] = 1'b0;
        rnd_stop = 1'b1;
      end
      begin
        while (!rnd_stop) begin
          @(posedge clk);
          #1;
          ready_i[d] = ($urandom_range(0, 3) != 0);
        end
      end
    join
    ready_i[d] = 1'b1;
    wait_drain(d);
  endtask

  function automatic logic [12:0] outv(input int d);
    return {valid_o[d], zero_o[d], neg_o[d], carry_o[d], ovf_o[d], result_o[d]};
  endfunction

  initial begin
    for (int d = 0; d < 2; d++) begin
      valid_i[d] = 1'b0; ready_i[d] = 1'b1; a_i[d] = 8'h00; b_i[d] = 8'h00;
      op_i[d] = 3'd0; acc_i[d] = 1'b0; acc_clr_i[d] = 1'b0; hold_v[d] = 1'b0;
    end
    macc[0] = ACC_R0;
    macc[1] = ACC_R1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_held0", 32'(outv(0)), {19'd0, 13'b0_1000_00000000});
    rst = 1'b0;
    for (int d = 0; d < 2; d++) begin
      @(negedge clk);
      check($sformatf("reset_state%0d", d), 32'({ready_o[d], outv(d)}), {18'd0, 14'b1_0_1000_00000000});
    end
    @(posedge clk);
    #1;

    // STAGES=1 directed opcodes: result visible one cycle after acceptance.
    send(0, 8'hF0, 8'h20, 3'd0, 1'b0); valid_i[0] = 1'b0;
    check("add_f0_20", 32'(outv(0)), {19'd0, 13'b1_0010_00010000});
    send(0, 8'h80, 8'h01, 3'd1, 1'b0); valid_i[0] = 1'b0;
    check("sub_80_01", 32'(outv(0)), {19'd0, 13'b1_0001_01111111});
    send(0, 8'hFF, 8'h01, 3'd5, 1'b0); valid_i[0] = 1'b0;
    check("slt_ff_01", 32'(outv(0)), {19'd0, 13'b1_0000_00000001});
    send(0, 8'h80, 8'h0B, 3'd7, 1'b0); valid_i[0] = 1'b0;
    check("srl_80_0b", 32'(outv(0)), {19'd0, 13'b1_0000_00010000});
    send(0, 8'h01, 8'hFF, 3'd6, 1'b0); valid_i[0] = 1'b0;
    check("sll_01_ff", 32'(outv(0)), {19'd0, 13'b1_0100_10000000});
    @(posedge clk);
    #1;

    // STAGES=2 accumulate chain after a clear.
    acc_clr_i[1] = 1'b1;
    @(posedge clk);
    #1;
    acc_clr_i[1] = 1'b0;
    send(1, 8'hEE, 8'd5, 3'd0, 1'b1);
    send(1, 8'hEE, 8'd7, 3'd0, 1'b1);
    check("acc_first", 32'({valid_o[1], result_o[1]}), {23'd0, 1'b1, 8'd5});
    send(1, 8'hEE, 8'd9, 3'd0, 1'b1);
    check("acc_second", 32'({valid_o[1], result_o[1]}), {23'd0, 1'b1, 8'd12});
    valid_i[1] = 1'b0;
    @(posedge clk);
    #1;
    check("acc_third", 32'({valid_o[1], result_o[1]}), {23'd0, 1'b1, 8'd21});
    wait_drain(1);

    // Backpressure: downstream stalls 3 cycles mid-stream.
    send(1, 8'h11, 8'h22, 3'd0, 1'b0);
    send(1, 8'h33, 8'h0F, 3'd2, 1'b0);
    ready_i[1] = 1'b0;
    @(negedge clk);
    check("ready_low_full", 32'(ready_o[1]), 32'd0);
    check("stall_head", 32'({valid_o[1], result_o[1]}), {23'd0, 1'b1, 8'h33});
    fork
      send(1, 8'h40, 8'h01, 3'd4, 1'b0);
      begin
        repeat (3) @(posedge clk);
        #1;
        ready_i[1] = 1'b1;
      end
    join
    send(1, 8'h05, 8'h09, 3'd1, 1'b0);
    valid_i[1] = 1'b0;
    wait_drain(1);

    random_phase(0);
    random_phase(1);

    // Asynchronous reset with results in flight.
    ready_i[0] = 1'b0;
    ready_i[1] = 1'b0;
    send(0, 8'h12, 8'h34, 3'd0, 1'b0); valid_i[0] = 1'b0;
    send(1, 8'h56, 8'h01, 3'd3, 1'b0);
    send(1, 8'h78, 8'h02, 3'd0, 1'b0); valid_i[1] = 1'b0;
    #3;
    rst = 1'b1;
    exp0.delete();
    exp1.delete();
    macc[0] = ACC_R0;
    macc[1] = ACC_R1;
    #1;
    check("async_drop0", 32'(valid_o[0]), 32'd0);
    check("async_drop1", 32'(valid_o[1]), 32'd0);
    ready_i[0] = 1'b1;
    ready_i[1] = 1'b1;
    repeat (2) @(posedge clk);
    #4;
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("no_stale0", 32'(valid_o[0]), 32'd0);
      check("no_stale1", 32'(valid_o[1]), 32'd0);
    end
    @(posedge clk);
    #1;
    send(0, 8'hAA, 8'h00, 3'd0, 1'b1); valid_i[0] = 1'b0;
    check("acc_after_reset0", 32'({valid_o[0], result_o[0]}), {23'd0, 1'b1, ACC_R0});
    send(1, 8'hAA, 8'h00, 3'd0, 1'b1); valid_i[1] = 1'b0;
    @(posedge clk);
    #1;
    check("acc_after_reset1", 32'({valid_o[1], zero_o[1], result_o[1]}), {22'd0, 2'b11, ACC_R1});
    wait_drain(0);
    wait_drain(1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
